// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage valid/ready bitwise gate unit with registered flags and completion counter
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       op_out,
  output logic             zero,
  output logic             all_ones,
  output logic             parity,
  output logic [CNT_W-1:0] done_cnt
);
  logic [WIDTH-1:0] s1_a_q, s1_b_q, res_d;
  logic [2:0]       s1_op_q;
  logic             s1_valid_q, s1_adv, s2_adv;
  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = s1_adv;
  // gate function selected by the stage-1 opcode
  always_comb begin
    res_d = s1_a_q & s1_b_q;
    case (s1_op_q)
      3'd0: res_d = s1_a_q & s1_b_q;
      3'd1: res_d = s1_a_q | s1_b_q;
      3'd2: res_d = ~s1_a_q;
      3'd3: res_d = ~s1_b_q;
      3'd4: res_d = ~(s1_a_q & s1_b_q);
      3'd5: res_d = ~(s1_a_q | s1_b_q);
      3'd6: res_d = s1_a_q ^ s1_b_q;
      3'd7: res_d = ~(s1_a_q ^ s1_b_q);
      default: ;
    endcase
  end
  // stage 1: capture operands whenever it can advance; valid tag follows in_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      s1_a_q     <= a;
      s1_b_q     <= b;
      s1_op_q    <= op;
    end
  end
  // stage 2: register result and flags together so they stay frozen under stall
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      op_out    <= '0;
      zero      <= 1'b0;
      all_ones  <= 1'b0;
      parity    <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid_q;
      result    <= res_d;
      op_out    <= s1_op_q;
      zero      <= res_d == '0;
      all_ones  <= &res_d;
      parity    <= ^res_d;
    end
  end
  // count completed output handshakes, wrapping naturally
  always_ff @(posedge clk) begin
    if (rst) done_cnt <= '0;
    else if (out_valid && out_ready) done_cnt <= done_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: scoreboard bench for logic_unit_pipe
module tb_logic_unit_pipe;
  logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic       in_ready, out_valid, zero, all_ones, parity;
  logic [7:0] result;
  logic [2:0] op_out;
  logic [15:0] done_cnt;
  logic       in_ready2, out_valid2, zero2, all_ones2, parity2;
  logic [7:0] result2;
  logic [2:0] op_out2;
  logic [1:0] done_cnt2;
  int n_chk = 0, n_fail = 0, n_done = 0, cyc = 0;
  bit seen = 0;
  typedef struct { logic [7:0] r; logic [2:0] o; int acc; bit lat; } exp_t;
  exp_t q[$];
  exp_t e;

  logic_unit_pipe u_dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .op_out(op_out), .zero(zero),
    .all_ones(all_ones), .parity(parity), .done_cnt(done_cnt));
  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready), .result(result2), .op_out(op_out2),
    .zero(zero2), .all_ones(all_ones2), .parity(parity2), .done_cnt(done_cnt2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: compares presented outputs against the head of the scoreboard
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      n_done = 0;
      seen = 0;
    end else begin
      chk("done_cnt", 32'(done_cnt), n_done);
      chk("done_cnt_w2", 32'(done_cnt2), n_done % 4);
      if (out_valid) begin
        if (q.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          e = q[0];
          if (!seen && e.lat) chk("latency", cyc, e.acc + 1);
          seen = 1;
          chk("result", 32'(result), 32'(e.r));
          chk("op_out", 32'(op_out), 32'(e.o));
          chk("zero", 32'(zero), 32'(e.r == 8'h00));
          chk("all_ones", 32'(all_ones), 32'(e.r == 8'hFF));
          chk("parity", 32'(parity), 32'(^e.r));
          if (out_ready) begin
            void'(q.pop_front());
            n_done++;
            seen = 0;
          end
        end
      end
    end
  end

  // called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [7:0] ta, input logic [7:0] tb2, input logic [2:0] top, input logic [7:0] er, input bit lat);
    bit ok = 0;
    in_valid = 1; a = ta; b = tb2; op = top;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{er, top, cyc + 1, lat});
        ok = 1;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain", q.size(), 0);
  endtask

  logic [7:0] sw_exp [8] = '{8'h05, 8'h5F, 8'hF0, 8'hAA, 8'hFA, 8'hA0, 8'h5A, 8'hA5};

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    out_ready = 0;
    send(8'h12, 8'h34, 3'd0, 8'h10, 0);
    send(8'h12, 8'h34, 3'd1, 8'h36, 0);
    rst = 1; in_valid = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0; in_valid = 0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_done_cnt", 32'(done_cnt), 0);
    chk("rst_result", 32'(result), 0);
    out_ready = 1;
    for (int i = 0; i < 8; i++) send(8'h0F, 8'h55, 3'(i), sw_exp[i], 1);
    drain();
    chk("sweep_done_cnt", 32'(done_cnt), 8);
    send(8'hFF, 8'hFF, 3'd0, 8'hFF, 1);
    send(8'hFF, 8'hFF, 3'd6, 8'h00, 1);
    send(8'h01, 8'h00, 3'd1, 8'h01, 1);
    drain();
    out_ready = 0;
    send(8'h3C, 8'h0F, 3'd0, 8'h0C, 0);
    send(8'h3C, 8'h0F, 3'd6, 8'h33, 0);
    in_valid = 1; a = 8'h3C; b = 8'h0F; op = 3'd5;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_same_edge_ready", 32'(in_ready), 1);
    chk("bp_same_edge_out", 32'(out_valid), 1);
    if (in_ready) q.push_back('{8'hC0, 3'd5, cyc + 1, 0});
    @(posedge clk); #1;
    in_valid = 0;
    drain();
    out_ready = 0;
    send(8'hA0, 8'h0A, 3'd1, 8'hAA, 0);
    send(8'hA0, 8'h0A, 3'd0, 8'h00, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("mid_rst_done_cnt", 32'(done_cnt), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    out_ready = 1;
    send(8'hF0, 8'h0F, 3'd7, 8'h00, 1);
    drain();
    send(8'hF0, 8'h0F, 3'd6, 8'hFF, 1);
    send(8'hC3, 8'h81, 3'd4, 8'h7E, 1);
    send(8'hC3, 8'h81, 3'd2, 8'h3C, 1);
    send(8'hC3, 8'h81, 3'd3, 8'h7E, 1);
    drain();
    chk("wrap_done_cnt", 32'(done_cnt2), 1);
    chk("wide_done_cnt", 32'(done_cnt), 5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the team's two-input combinational gate block.
- Applies one of eight bitwise gate functions to two WIDTH-bit operands, selected per transaction by an opcode.
- Carries each transaction through a two-stage valid/ready pipeline with full backpressure.
- Also produces registered reduction flags and a count of completed results.
- Sits between an operand source (a stimulus generator or register file) and any consumer that may stall.

Parameters:
- WIDTH, 8, operand and result width in bits (≥1).
- CNT_W, 16, width of the completed-result counter (≥1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset. One clock; reset is sampled only on the rising edge of clk.
- in_valid  input  1  the a/b/op inputs carry a transaction.
- in_ready  output  1  the block can accept a transaction this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  3  function select: 0 AND, 1 OR, 2 NOT A, 3 NOT B, 4 NAND, 5 NOR, 6 XOR, 7 XNOR.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  the consumer accepts the result this cycle.
- result  output  WIDTH  bitwise gate result.
- op_out  output  3  opcode that produced result.
- zero  output  1  result is all zeros.
- all_ones  output  1  result is all ones.
- parity  output  1  XOR reduction of result.
- done_cnt  output  CNT_W  number of completed output handshakes.

Behaviour:
- Reset (rst=1 at a clk edge):
  - s1_valid, out_valid, result, op_out, zero, all_ones, parity and done_cnt all go to 0.
  - Pipeline contents are discarded, including a transaction that is mid-flight.
  - in_ready reads 1 in the first cycle after reset, because it is derived combinationally from the cleared pipeline.
- Stage 1 (input register): holds s1_a, s1_b, s1_op and s1_valid.
- Stage 2 (output register):
  - Holds result, op_out, the three flags and out_valid.
  - Gate function and flags are computed combinationally from stage 1 and registered here.
- Advance rules (combinational):
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv. in_ready depends on out_ready combinationally; this path is accepted.
- Clock edges:
  - When s2_adv: stage 2 loads the function of stage 1, and out_valid <= s1_valid.
  - When s1_adv: stage 1 loads a/b/op, and s1_valid <= in_valid.
  - Any register whose advance signal is low holds its value exactly. Output data must not change while out_valid=1 and out_ready=0.
- Handshakes:
  - Input accepted when in_valid & in_ready.
  - Output completes when out_valid & out_ready.
- Latency and throughput:
  - A transaction accepted at edge k appears with out_valid=1 after edge k+1.
  - Sustained throughput is 1 per cycle when out_ready=1.
- Capacity:
  - Capacity is 2 transactions.
  - With out_ready held 0, two transactions are accepted, then in_ready=0.
  - When out_ready returns to 1, in_ready returns to 1 in the same cycle, so an accept and a complete can happen on the same edge.
- Flags:
  - zero = (result == 0); all_ones = (result == all ones); parity = ^result.
  - All three are registered together with result.
  - For WIDTH=1, zero and all_ones are complementary.
- done_cnt:
  - Increments by 1 on each completed output handshake.
  - Wraps from 2^CNT_W−1 to 0.
  - Unaffected by stalls.
- Sampling: a and b are don't-care when in_valid=0 and are still sampled when s1_adv is high, but stage 1 is tagged invalid.

Test Plan:
- Reset with rst=1 for 2 cycles while in_valid=1 and the pipeline is full → next cycle out_valid=0, in_ready=1, done_cnt=0, result=0.
- WIDTH=8, a=0x0F, b=0x55, op swept 0..7 back-to-back with out_ready=1:
  - Results in order 05, 5F, F0, AA, FA, A0, 5A, A5.
  - The first appears 2 edges after its accept; one result per cycle thereafter.
  - done_cnt=8 at the end.
- Flags:
  - a=0xFF, b=0xFF, op=0 → result FF, all_ones=1, zero=0, parity=0.
  - op=6 → result 00, zero=1.
  - a=0x01, b=0x00, op=1 → parity=1.
- Backpressure:
  - out_ready=0, in_valid=1 with 3 distinct transactions → exactly 2 accepted, in_ready=0, result stable for 5 held cycles.
  - Raise out_ready → third transaction accepted on the same edge as the first completes; outputs in original order, none lost or duplicated.
- Mid-operation reset: rst asserted for 1 cycle with 2 transactions in flight → both dropped, done_cnt=0, and the next accepted transaction has latency 2.
- Counter wrap with CNT_W=2: 5 completed handshakes → done_cnt sequence 1, 2, 3, 0, 1.
